ifft_frame_sink: RTL and testbench
==================================

Name: ifft_frame_sink

Overview:
Consumer end of the IFFT output stream. It accepts 512-point Avalon-ST frames (valid/ready/sop/eop/error/real) and checks their framing. Good frames are stored in a ping-pong buffer, and samples are played out one per audio sample strobe as a continuous PCM stream to the audio codec path. Bad frames are discarded, and silence is inserted on underrun.

Parameters:
DATA_W, 16, sample width of sink_real and audio_out
FRAME_LEN, 512, samples per frame; must be a power of two
ADDR_W, 9, log2(FRAME_LEN)

Ports:
clk  in  1  system clock; everything is on its rising edge
reset  in  1  synchronous, active-high reset
sink_valid  in  1  beat valid from IFFT source
sink_ready  out  1  block can accept a beat this cycle
sink_sop  in  1  first beat of frame
sink_eop  in  1  last beat of frame
sink_error  in  1  upstream error flag on this beat
sink_real  in  DATA_W  signed sample
sample_tick  in  1  one-cycle audio-rate strobe requesting the next sample
audio_out  out  DATA_W  signed output sample, held between updates
audio_valid  out  1  one-cycle pulse, audio_out updated
frame_err  out  1  one-cycle pulse, frame discarded
underrun  out  1  one-cycle pulse, tick arrived with no full bank

Behaviour:
- Beat accepted when sink_valid && sink_ready.
- Reset values: sink_ready=0, audio_out=0, audio_valid=0, frame_err=0, underrun=0. Both banks empty, wbank=0, rbank=0, all indices 0.
- Reset mid-frame discards all buffered data. sink_ready returns to 1 on the first cycle after reset deasserts.
- sink_ready = !reset && !full[wbank]. It depends on registered state only, never combinationally on sink_valid.
- Write FSM, state W_IDLE:
  - Accepted beat with sop: write to index 0, set widx=1, go to W_FILL.
  - Accepted beat without sop: dropped, no frame_err.
- Write FSM, state W_FILL, per accepted beat:
  - sink_error=1: discard frame, pulse frame_err, go to W_IDLE.
  - sop=1: restart at index 0 in the same bank and pulse frame_err.
  - eop=1 with widx!=FRAME_LEN-1: discard, pulse frame_err, go to W_IDLE.
  - widx==FRAME_LEN-1 with eop=0: discard, pulse frame_err, go to W_IDLE.
  - widx==FRAME_LEN-1 with eop=1: write the beat, set full[wbank]=1, toggle wbank, go to W_IDLE.
  - Otherwise: write the beat at widx, then widx++.
- A frame is only committed complete and error-free; partial data is never read.
- Read side, on sample_tick:
  - full[rbank]=1: read RAM at {rbank,ridx}. One cycle later audio_out = the data and audio_valid=1.
  - Then ridx++. If ridx was FRAME_LEN-1: clear full[rbank], toggle rbank, ridx=0.
  - full[rbank]=0: one cycle later audio_out=0, audio_valid=1 and underrun=1, so the output rate is preserved.
- Latency: sample_tick to audio_valid is exactly 1 cycle. Ticks on consecutive cycles are each honoured.
- Commit and release in the same cycle: the write side sets full[wbank] and the read side clears full[rbank] in that one cycle, with no lost update.
- Wrap-around: widx and ridx wrap at FRAME_LEN. The bank index is the address MSB.
- RAM behaviour:
  - Write and read in the same cycle always hit different banks, because the write bank is never full while being filled and the read bank is always full, so no collision forwarding is needed.
  - Read-during-write to the same address cannot occur.

Decomposition:
- Package ifft_sink_pkg holds:
  - FRAME_LEN, ADDR_W and DATA_W defaults.
  - The write-FSM state enum {W_IDLE, W_FILL}.
- One sub-module, frame_pingpong_ram:
  - Simple dual-port, 2*FRAME_LEN x DATA_W.
  - One write port and one registered read port with 1-cycle latency.
  - Inferable to block RAM.
- Control logic and counters live in ifft_frame_sink.

Test Plan:
1. Clean frame, sink_real = 0..511 with sop on beat 0 and eop on beat 511, then 512 ticks → audio_out = 0,1,...,511, each 1 cycle after its tick, no frame_err or underrun.
2. sop reasserted at beat 100, then a clean 512-beat frame of value 7 → exactly one frame_err pulse, then 512 outputs all equal to 7.
3. eop at beat 300, also a frame with sink_error on beat 5 → one frame_err per frame, nothing committed, ticks produce 0 with underrun.
4. Three back-to-back clean frames with no ticks → sink_ready drops to 0 after the second eop. The third frame's first beat is stalled until 512 ticks drain bank 0, then it is accepted and data order is preserved.
5. Tick with empty buffer → audio_out=0, audio_valid=1, underrun=1 one cycle later. A tick on the same cycle as a commit also underruns, and the next tick returns sample 0 of the new frame.
6. Reset asserted at beat 200 of a frame and after half a bank is played → all outputs 0, sink_ready=0 during reset. A subsequent clean frame plays out from index 0.

Source files
------------

// File: rtl/ifft_sink_pkg.sv
// Shared defaults and types for the IFFT frame sink and its ping-pong RAM.
package ifft_sink_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAME_LEN_DEF = 512;
  localparam int ADDR_W_DEF    = 9;

  // Write side either waits for a start-of-frame or is filling a bank.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wstate_e;

endpackage

// File: rtl/frame_pingpong_ram.sv
// Two-bank sample store: one write port, one registered read port.
// The bank select is the address MSB, so each bank holds one whole frame.
module frame_pingpong_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: data appears the cycle after re_i and holds until the next read.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft_frame_sink.sv
// Checks IFFT output framing, commits only complete error-free frames into a
// ping-pong buffer and plays them out one sample per audio tick, inserting
// silence whenever no full bank is ready.
module ifft_frame_sink
  import ifft_sink_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  input  logic                     sink_error,
  input  logic signed [DATA_W-1:0] sink_real,
  input  logic                     sample_tick,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     audio_valid,
  output logic                     frame_err,
  output logic                     underrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  wstate_e           wState_q, wState_d;
  logic [ADDR_W-1:0] wIdx_q, wIdx_d;
  logic [ADDR_W-1:0] rIdx_q, rIdx_d;
  logic              wBank_q, wBank_d;
  logic              rBank_q, rBank_d;
  logic [1:0]        full_q, full_d;
  logic              frameErr_q, frameErr_d;
  logic              audioValid_q, underrun_q, zeroOut_q;

  logic              accept, commit, relBank;
  logic              ramWe, ramRe;
  logic [ADDR_W-1:0] ramWIdx;
  logic [DATA_W-1:0] ramRdata;

  // Ready depends only on registered bank state, never on sink_valid.
  assign sink_ready = !reset && !full_q[wBank_q];
  assign accept     = sink_valid && sink_ready;

  // Write FSM: framing checks decide whether each beat is stored, restarts
  // the frame, aborts it, or completes and commits the bank.
  always_comb begin
    wState_d   = wState_q;
    wIdx_d     = wIdx_q;
    wBank_d    = wBank_q;
    ramWe      = 1'b0;
    ramWIdx    = wIdx_q;
    commit     = 1'b0;
    frameErr_d = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (accept && sink_sop) begin
          ramWe    = 1'b1;
          ramWIdx  = '0;
          wIdx_d   = ADDR_W'(1);
          wState_d = W_FILL;
        end
      end
      W_FILL: begin
        if (accept) begin
          if (sink_error) begin
            frameErr_d = 1'b1;
            wIdx_d     = '0;
            wState_d   = W_IDLE;
          end else if (sink_sop) begin
            ramWe      = 1'b1;
            ramWIdx    = '0;
            wIdx_d     = ADDR_W'(1);
            frameErr_d = 1'b1;
          end else if (sink_eop != (wIdx_q == LAST_IDX)) begin
            frameErr_d = 1'b1;
            wIdx_d     = '0;
            wState_d   = W_IDLE;
          end else if (sink_eop) begin
            ramWe    = 1'b1;
            commit   = 1'b1;
            wBank_d  = !wBank_q;
            wIdx_d   = '0;
            wState_d = W_IDLE;
          end else begin
            ramWe  = 1'b1;
            wIdx_d = wIdx_q + 1'b1;
          end
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Read side: a tick on a full bank fetches the next sample and releases the
  // bank after its last sample.
  always_comb begin
    rIdx_d  = rIdx_q;
    rBank_d = rBank_q;
    ramRe   = 1'b0;
    relBank = 1'b0;
    if (sample_tick && full_q[rBank_q]) begin
      ramRe  = 1'b1;
      rIdx_d = rIdx_q + 1'b1;
      if (rIdx_q == LAST_IDX) begin
        relBank = 1'b1;
        rIdx_d  = '0;
        rBank_d = !rBank_q;
      end
    end
  end

  // Commit and release always target different banks, so both apply together.
  always_comb begin
    full_d = full_q;
    if (commit)  full_d[wBank_q] = 1'b1;
    if (relBank) full_d[rBank_q] = 1'b0;
  end

  // State registers and one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wState_q     <= W_IDLE;
      wIdx_q       <= '0;
      rIdx_q       <= '0;
      wBank_q      <= 1'b0;
      rBank_q      <= 1'b0;
      full_q       <= '0;
      frameErr_q   <= 1'b0;
      audioValid_q <= 1'b0;
      underrun_q   <= 1'b0;
      zeroOut_q    <= 1'b1;
    end else begin
      wState_q     <= wState_d;
      wIdx_q       <= wIdx_d;
      rIdx_q       <= rIdx_d;
      wBank_q      <= wBank_d;
      rBank_q      <= rBank_d;
      full_q       <= full_d;
      frameErr_q   <= frameErr_d;
      audioValid_q <= sample_tick;
      underrun_q   <= sample_tick && !full_q[rBank_q];
      if (sample_tick) zeroOut_q <= !full_q[rBank_q];
    end
  end

  frame_pingpong_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ramWe),
    .waddr_i ({wBank_q, ramWIdx}),
    .wdata_i (sink_real),
    .re_i    (ramRe),
    .raddr_i ({rBank_q, rIdx_q}),
    .rdata_o (ramRdata)
  );

  assign audio_out   = zeroOut_q ? '0 : ramRdata;
  assign audio_valid = audioValid_q;
  assign frame_err   = frameErr_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_ifft_frame_sink.sv
// Randomized scoreboard bench for ifft_frame_sink. The driver feeds a
// frame-level reference model that predicts every audio sample and every
// frame_err pulse; a monitor pops predictions whenever the DUT presents them.
module tb_ifft_frame_sink;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              sink_valid, sink_ready, sink_sop, sink_eop, sink_error;
  logic [DATA_W-1:0] sink_real;
  logic              sample_tick;
  logic [DATA_W-1:0] audio_out;
  logic              audio_valid, frame_err, underrun;

  ifft_frame_sink dut (
    .clk         (clk),
    .reset       (reset),
    .sink_valid  (sink_valid),
    .sink_ready  (sink_ready),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_error  (sink_error),
    .sink_real   (sink_real),
    .sample_tick (sample_tick),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .frame_err   (frame_err),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int bubblePct = 0;
  bit rstSeen = 1'b0;

  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
    rstSeen <= reset;
  end

  typedef struct packed {
    logic [31:0]       stamp;
    logic [DATA_W-1:0] data;
    logic              under;
  } audExp_t;

  // Reference model: committed samples in play order, the frame being
  // assembled, and the expected outputs with the cycle they must appear in.
  logic [DATA_W-1:0] pendQ[$];
  logic [DATA_W-1:0] partQ[$];
  bit                inFrame = 1'b0;
  audExp_t           audQ[$];
  int                errQ[$];
  logic [DATA_W-1:0] holdVal = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Two full frames waiting means both banks are occupied.
  function automatic bit modelReady();
    return pendQ.size() <= FRAME_LEN;
  endfunction

  task automatic modelBeat(input bit sop, input bit eop, input bit err, input logic [DATA_W-1:0] d);
    if (!inFrame) begin
      if (sop) begin
        partQ.delete();
        partQ.push_back(d);
        inFrame = 1'b1;
      end
    end else if (err) begin
      inFrame = 1'b0;
      errQ.push_back(cycleCnt + 1);
    end else if (sop) begin
      partQ.delete();
      partQ.push_back(d);
      errQ.push_back(cycleCnt + 1);
    end else begin
      partQ.push_back(d);
      if (partQ.size() == FRAME_LEN) begin
        inFrame = 1'b0;
        if (eop) begin
          foreach (partQ[i]) pendQ.push_back(partQ[i]);
        end else begin
          errQ.push_back(cycleCnt + 1);
        end
      end else if (eop) begin
        inFrame = 1'b0;
        errQ.push_back(cycleCnt + 1);
      end
    end
  endtask

  // One clock of stimulus; the model sees the tick before any commit.
  task automatic applyStimulus(input bit v, input bit sop, input bit eop, input bit err,
                               input logic [DATA_W-1:0] d, input bit tick, output bit accepted);
    bit rdy;
    audExp_t e;
    sink_valid  = v;
    sink_sop    = sop;
    sink_eop    = eop;
    sink_error  = err;
    sink_real   = d;
    sample_tick = tick;
    @(negedge clk);
    rdy = modelReady();
    checkOutput("sink_ready", {31'd0, sink_ready}, {31'd0, rdy});
    if (tick) begin
      e.stamp = cycleCnt + 1;
      if (pendQ.size() > 0) begin
        e.data  = pendQ.pop_front();
        e.under = 1'b0;
      end else begin
        e.data  = '0;
        e.under = 1'b1;
      end
      audQ.push_back(e);
    end
    accepted = v && rdy;
    if (accepted) modelBeat(sop, eop, err, d);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 1'b0;
    sink_real = '0; sample_tick = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkOutput("sink_ready in reset", {31'd0, sink_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    pendQ.delete();
    partQ.delete();
    inFrame = 1'b0;
    reset = 1'b0;
  endtask

  task automatic sendBeat(input bit sop, input bit eop, input bit err, input logic [DATA_W-1:0] d,
                          input int tickPct, input bit tickOnStall);
    bit acc, tick;
    int waitC;
    acc = 1'b0;
    waitC = 0;
    if (bubblePct > 0 && $urandom_range(0, 99) < bubblePct)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, ($urandom_range(0, 99) < tickPct), acc);
    do begin
      tick = ($urandom_range(0, 99) < tickPct) || (tickOnStall && !modelReady());
      applyStimulus(1'b1, sop, eop, err, d, tick, acc);
      waitC++;
    end while (!acc && waitC < 4000);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat accept timeout: beat not accepted after %0d cycles", waitC);
    end
  endtask

  // mode: 0 ramp, 1 constant 7, 2 random. fault: 0 none, 1 sink_error at
  // faultAt (rest still sent), 2 early eop at faultAt, 3 stop before faultAt.
  task automatic sendFrame(input int mode, input int fault, input int faultAt,
                           input int tickPct, input bit tickOnStall);
    logic [DATA_W-1:0] d;
    bit eop;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (fault == 3 && i == faultAt) return;
      case (mode)
        0:       d = DATA_W'(i);
        1:       d = DATA_W'(7);
        default: d = DATA_W'($urandom);
      endcase
      eop = (i == FRAME_LEN - 1) || (fault == 2 && i == faultAt);
      sendBeat(i == 0, eop, (fault == 1 && i == faultAt), d, tickPct, tickOnStall);
      if (fault == 2 && i == faultAt) return;
    end
  endtask

  task automatic idleTicks(input int n, input int tickPct);
    bit acc;
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, ($urandom_range(0, 99) < tickPct), acc);
  endtask

  // Monitor: pops predictions when the DUT presents output, flags late or
  // unexpected pulses, and checks audio_out holds between updates.
  always @(negedge clk) begin
    audExp_t e;
    int s;
    if (rstSeen) begin
      holdVal = '0;
      checkOutput("audio_out in reset", {16'd0, audio_out}, 32'd0);
      checkOutput("audio_valid in reset", {31'd0, audio_valid}, 32'd0);
      checkOutput("pulses in reset", {30'd0, frame_err, underrun}, 32'd0);
    end else begin
      while (audQ.size() > 0 && int'(audQ[0].stamp) < cycleCnt) begin
        e = audQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL audio_valid missing: expected at cycle %0d, now %0d", e.stamp, cycleCnt);
      end
      if (audio_valid) begin
        if (audQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL audio_valid unexpected: got pulse with audio_out %0h, expected none", audio_out);
        end else begin
          e = audQ.pop_front();
          checkOutput("audio latency", cycleCnt, e.stamp);
          checkOutput("audio_out", {16'd0, audio_out}, {16'd0, e.data});
          checkOutput("underrun", {31'd0, underrun}, {31'd0, e.under});
          holdVal = e.data;
        end
      end else begin
        checkOutput("audio_out hold", {16'd0, audio_out}, {16'd0, holdVal});
        checkOutput("underrun without valid", {31'd0, underrun}, 32'd0);
      end
      while (errQ.size() > 0 && errQ[0] < cycleCnt) begin
        s = errQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL frame_err missing: expected at cycle %0d, now %0d", s, cycleCnt);
      end
      if (frame_err) begin
        if (errQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame_err unexpected: got 1, expected 0 at cycle %0d", cycleCnt);
        end else begin
          s = errQ.pop_front();
          checkOutput("frame_err timing", cycleCnt, s);
        end
      end
    end
  end

  initial begin
    int k, ft;
    reset = 1'b1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 1'b0;
    sink_real = '0; sample_tick = 1'b0;
    applyReset(3);

    $display("[TB] clean ramp frame");
    sendFrame(0, 0, 0, 0, 1'b0);
    idleTicks(FRAME_LEN, 100);

    $display("[TB] sop restart at beat 100 then constant frame");
    sendFrame(2, 3, 100, 0, 1'b0);
    sendFrame(1, 0, 0, 0, 1'b0);
    idleTicks(FRAME_LEN, 100);

    $display("[TB] early eop and sink_error frames");
    sendFrame(2, 2, 300, 0, 1'b0);
    sendFrame(2, 1, 5, 0, 1'b0);
    idleTicks(20, 100);

    $display("[TB] three back-to-back frames with backpressure");
    sendFrame(0, 0, 0, 0, 1'b1);
    sendFrame(1, 0, 0, 0, 1'b1);
    sendFrame(2, 0, 0, 0, 1'b1);
    idleTicks(2 * FRAME_LEN + 80, 100);

    $display("[TB] underrun and tick coinciding with commit");
    idleTicks(3, 100);
    sendFrame(2, 3, FRAME_LEN - 1, 0, 1'b0);
    sendBeat(1'b0, 1'b1, 1'b0, DATA_W'($urandom), 100, 1'b0);
    idleTicks(FRAME_LEN, 100);

    $display("[TB] reset mid-frame with half a bank played");
    sendFrame(2, 0, 0, 0, 1'b0);
    sendFrame(2, 3, 200, 100, 1'b0);
    idleTicks(56, 100);
    applyReset(3);
    sendFrame(0, 0, 0, 0, 1'b0);
    idleTicks(FRAME_LEN, 100);

    $display("[TB] random frames, faults, ticks and bubbles");
    bubblePct = 10;
    repeat (6) begin
      k  = $urandom_range(0, 4);
      ft = (k < 3) ? 0 : k - 2;
      sendFrame(2, ft, $urandom_range(1, FRAME_LEN - 2), 50, 1'b0);
    end
    bubblePct = 0;
    idleTicks(3 * FRAME_LEN + 100, 100);
    idleTicks(4, 0);

    checkOutput("audio predictions drained", audQ.size(), 32'd0);
    checkOutput("frame_err predictions drained", errQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
